// File: rtl/ibex_fdiv_arbiter.sv
// ibex_fdiv_arbiter: shares one multi-cycle FP32 divider between NUM_REQ requesters.
//
// A round-robin arbiter picks one requester while idle, latches its operands and
// drives the divider's enable for EN_HOLD cycles. It then waits for the divider's
// valid pulse and routes the result back to the owner as a one-cycle strobe. If the
// divider never answers, a watchdog pulses the divider reset and returns a quiet NaN
// flagged as a timeout. A requester may flush its own in-flight operation. The
// operation still runs to completion, because the divider cannot be aborted, but its
// response strobe is suppressed.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_i, req_a_i, req_b_i      per-requester request and operands (slice i = [32*i+:32])
//   flush_i                      per-requester kill of its in-flight operation
//   gnt_o                        one-hot grant pulse; operands are sampled on this edge
//   rsp_valid_o, rsp_result_o    one-hot response strobe and result
//   rsp_timeout_o                response produced by watchdog recovery
//   busy_o                       arbiter not idle
//   div_en_o, div_a_o, div_b_o   divider start and operands
//   div_rst_no                   divider reset, active-low
//   div_result_i, div_valid_i    divider result and completion pulse
module ibex_fdiv_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned EN_HOLD        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*32-1:0] req_a_i,
  input  logic [NUM_REQ*32-1:0] req_b_i,
  input  logic [NUM_REQ-1:0]   flush_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [NUM_REQ-1:0]   rsp_valid_o,
  output logic [31:0]          rsp_result_o,
  output logic                 rsp_timeout_o,
  output logic                 busy_o,
  output logic                 div_en_o,
  output logic [31:0]          div_a_o,
  output logic [31:0]          div_b_o,
  output logic                 div_rst_no,
  input  logic [31:0]          div_result_i,
  input  logic                 div_valid_i
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT_CYCLES + 1);
  // en_cnt also counts the two recovery cycles, so it needs at least one bit.
  localparam int unsigned CntW = ($clog2(EN_HOLD) < 1) ? 1 : $clog2(EN_HOLD);
  localparam logic [31:0] QNaN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StRecover,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]         a_q, a_d;
  logic [31:0]         b_q, b_d;
  logic [NUM_REQ-1:0]  id_q, id_d;
  logic                killed_q, killed_d;
  logic [31:0]         res_q, res_d;
  logic                to_q, to_d;
  logic [CntW-1:0]     en_cnt_q, en_cnt_d;
  logic [WdW-1:0]      wd_cnt_q, wd_cnt_d;

  logic                gnt_found;
  logic [PtrW-1:0]     gnt_idx;
  logic [PtrW-1:0]     cand;

  // Round-robin search: first set request at or after rr_ptr_q, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = (cand == PtrW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    killed_d = killed_q;
    res_d    = res_q;
    to_d     = to_q;
    en_cnt_d = en_cnt_q;
    wd_cnt_d = wd_cnt_q;

    // Only the owner of the in-flight operation can kill it.
    if ((state_q == StIssue || state_q == StWait || state_q == StRecover) &&
        |(flush_i & id_q)) begin
      killed_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (gnt_found) begin
          a_d           = req_a_i[32*gnt_idx +: 32];
          b_d           = req_b_i[32*gnt_idx +: 32];
          id_d          = '0;
          id_d[gnt_idx] = 1'b1;
          killed_d      = 1'b0;
          rr_ptr_d      = (gnt_idx == PtrW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          en_cnt_d      = '0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (en_cnt_q == CntW'(EN_HOLD - 1)) begin
          wd_cnt_d = '0;
          state_d  = StWait;
        end else begin
          en_cnt_d = en_cnt_q + 1'b1;
        end
      end
      StWait: begin
        // A valid pulse on the watchdog limit cycle still counts as a real result.
        if (div_valid_i) begin
          res_d   = div_result_i;
          to_d    = 1'b0;
          state_d = StResp;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (wd_cnt_d == WdW'(TIMEOUT_CYCLES)) begin
            en_cnt_d = '0;
            state_d  = StRecover;
          end
        end
      end
      StRecover: begin
        if (en_cnt_q == CntW'(1)) begin
          res_d   = QNaN;
          to_d    = 1'b1;
          state_d = StResp;
        end else begin
          en_cnt_d = en_cnt_q + 1'b1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      killed_q <= 1'b0;
      res_q    <= '0;
      to_q     <= 1'b0;
      en_cnt_q <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      killed_q <= killed_d;
      res_q    <= res_d;
      to_q     <= to_d;
      en_cnt_q <= en_cnt_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Output decode. Reset forces every output to its idle value, and holds the divider in reset.
  always_comb begin
    gnt_o         = '0;
    rsp_valid_o   = '0;
    rsp_result_o  = '0;
    rsp_timeout_o = 1'b0;
    busy_o        = 1'b0;
    div_en_o      = 1'b0;
    div_a_o       = '0;
    div_b_o       = '0;
    div_rst_no    = 1'b1;
    if (rst_i) begin
      div_rst_no = 1'b0;
    end else begin
      busy_o = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          if (gnt_found) begin
            gnt_o[gnt_idx] = 1'b1;
          end
        end
        StIssue: begin
          div_en_o = 1'b1;
          div_a_o  = a_q;
          div_b_o  = b_q;
        end
        StWait: begin
          div_a_o = a_q;
          div_b_o = b_q;
        end
        StRecover: begin
          div_a_o    = a_q;
          div_b_o    = b_q;
          div_rst_no = 1'b0;
        end
        StResp: begin
          rsp_valid_o   = killed_q ? '0 : id_q;
          rsp_result_o  = res_q;
          rsp_timeout_o = to_q;
        end
        default: ;
      endcase
    end
  end

endmodule
